// File: rtl/decode_regfile_sb.sv
// Decode-stage register file with a per-register pending-write scoreboard.
// Provides write-first bypass reads, issue stall generation and flush of outstanding long-latency writes.
module decode_regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int RD_PORTS = 2,
  parameter int MAX_PEND = 3,
  parameter int ZERO_REG = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
  input  logic [RD_PORTS-1:0]          rd_used,
  output logic [RD_PORTS*DATA_W-1:0]   rd_data,
  output logic [RD_PORTS-1:0]          rd_pend,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         wr_long,
  input  logic                         iss_valid,
  input  logic                         iss_long,
  input  logic [ADDR_W-1:0]            iss_rd,
  input  logic                         flush,
  output logic                         stall,
  output logic                         busy,
  output logic                         sb_err
);

  localparam int CNT_W = $clog2(MAX_PEND + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PEND);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [CNT_W-1:0]  cnt  [NUM_REGS];
  logic              err_q;

  logic wr_zero, wr_ok, retire;
  logic iss_zero, iss_full, dep_stall, accept;
  logic [NUM_REGS-1:0] inc_vec, dec_vec;
  logic busy_c;

  assign wr_zero  = (ZERO_REG != 0) && (wr_addr == '0);
  assign wr_ok    = wr_en && !wr_zero;
  assign retire   = wr_ok && wr_long;
  assign iss_zero = (ZERO_REG != 0) && (iss_rd == '0);

  // Per-port read: zero register, then bypass of the same-cycle write, then storage.
  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              zero_rd;
    assign a       = rd_addr[p*ADDR_W +: ADDR_W];
    assign zero_rd = (ZERO_REG != 0) && (a == '0);
    assign rd_data[p*DATA_W +: DATA_W] = zero_rd ? '0 :
                                         (wr_ok && (wr_addr == a)) ? wr_data : regs[a];
    assign rd_pend[p] = !zero_rd && (cnt[a] != '0) &&
                        !((cnt[a] == CNT_ONE) && retire && (wr_addr == a));
  end

  assign dep_stall = |(rd_used & rd_pend);
  assign iss_full  = iss_long && (cnt[iss_rd] == CNT_MAX) && !(retire && (wr_addr == iss_rd));
  assign stall     = iss_valid && (dep_stall || iss_full);
  assign accept    = iss_valid && !stall && iss_long && !iss_zero;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (accept) inc_vec[iss_rd] = 1'b1;
    if (retire) dec_vec[wr_addr] = 1'b1;
  end

  always_comb begin
    busy_c = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) busy_c = busy_c | (cnt[r] != '0);
  end

  assign busy   = busy_c;
  assign sb_err = err_q;

  // A matched issue/retire on one register cancels out; counters saturate rather than wrap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
      err_q <= 1'b0;
    end else begin
      if (wr_ok) regs[wr_addr] <= wr_data;
      for (int r = 0; r < NUM_REGS; r++) begin
        if (flush) begin
          cnt[r] <= '0;
        end else if (inc_vec[r] && !dec_vec[r] && (cnt[r] != CNT_MAX)) begin
          cnt[r] <= cnt[r] + CNT_ONE;
        end else if (dec_vec[r] && !inc_vec[r] && (cnt[r] != '0)) begin
          cnt[r] <= cnt[r] - CNT_ONE;
        end
      end
      if (retire && !inc_vec[wr_addr] && (cnt[wr_addr] == '0)) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_regfile_sb.sv
// Self-checking bench for decode_regfile_sb: a behavioural scoreboard model checked every cycle
// plus directed scenarios with hand-computed literal expectations.
module tb_decode_regfile_sb;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  rd_addr;
  logic [1:0]  rd_used;
  logic [63:0] rd_data;
  logic [1:0]  rd_pend;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_long;
  logic        iss_valid;
  logic        iss_long;
  logic [4:0]  iss_rd;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        sb_err;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_regs [32] = '{default: 32'h0};
  int          m_cnt  [32] = '{default: 0};
  logic        m_err = 1'b0;

  decode_regfile_sb dut (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_used(rd_used),
    .rd_data(rd_data), .rd_pend(rd_pend), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_long(wr_long), .iss_valid(iss_valid), .iss_long(iss_long),
    .iss_rd(iss_rd), .flush(flush), .stall(stall), .busy(busy), .sb_err(sb_err)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model reads follow the rules directly: register 0 is zero, a live write wins, else storage.
  function automatic logic [31:0] mRead(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (wr_en && wr_addr == a) return wr_data;
    return m_regs[a];
  endfunction

  function automatic logic mPend(input logic [4:0] a);
    if (a == 5'd0 || m_cnt[a] == 0) return 1'b0;
    if (m_cnt[a] == 1 && wr_en && wr_long && wr_addr == a) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic mStall();
    logic dep, full;
    if (!iss_valid) return 1'b0;
    dep  = (rd_used[0] && mPend(rd_addr[4:0])) || (rd_used[1] && mPend(rd_addr[9:5]));
    full = iss_long && m_cnt[iss_rd] == 3 && !(wr_en && wr_long && wr_addr == iss_rd);
    return dep || full;
  endfunction

  function automatic logic mBusy();
    foreach (m_cnt[r]) if (m_cnt[r] != 0) return 1'b1;
    return 1'b0;
  endfunction

  initial forever begin
    logic ret, acc;
    @(posedge clock or negedge reset);
    if (!reset) begin
      foreach (m_cnt[r]) begin m_cnt[r] = 0; m_regs[r] = 32'h0; end
      m_err = 1'b0;
    end else begin
      ret = wr_en && wr_long && wr_addr != 5'd0;
      acc = iss_valid && !mStall() && iss_long && iss_rd != 5'd0;
      if (ret && m_cnt[wr_addr] == 0 && !(acc && iss_rd == wr_addr)) m_err = 1'b1;
      if (flush) begin
        foreach (m_cnt[r]) m_cnt[r] = 0;
      end else if (!(acc && ret && iss_rd == wr_addr)) begin
        if (acc && m_cnt[iss_rd] < 3) m_cnt[iss_rd] = m_cnt[iss_rd] + 1;
        if (ret && m_cnt[wr_addr] > 0) m_cnt[wr_addr] = m_cnt[wr_addr] - 1;
      end
      if (wr_en && wr_addr != 5'd0) m_regs[wr_addr] = wr_data;
    end
  end

  initial forever begin
    @(negedge clock);
    checkOutput("cmp_rd_data0", {32'h0, rd_data[31:0]},  {32'h0, mRead(rd_addr[4:0])});
    checkOutput("cmp_rd_data1", {32'h0, rd_data[63:32]}, {32'h0, mRead(rd_addr[9:5])});
    checkOutput("cmp_rd_pend",  {62'h0, rd_pend}, {62'h0, mPend(rd_addr[9:5]), mPend(rd_addr[4:0])});
    checkOutput("cmp_stall",    {63'h0, stall},   {63'h0, mStall()});
    checkOutput("cmp_busy",     {63'h0, busy},    {63'h0, mBusy()});
    checkOutput("cmp_sb_err",   {63'h0, sb_err},  {63'h0, m_err});
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic applyStimulus(input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] used);
    rd_addr = {a1, a0};
    rd_used = used;
  endtask

  task automatic setIdle();
    rd_addr = '0; rd_used = '0; wr_en = 0; wr_addr = '0; wr_data = '0; wr_long = 0;
    iss_valid = 0; iss_long = 0; iss_rd = '0; flush = 0;
  endtask

  task automatic issueLong(input logic [4:0] r);
    iss_valid = 1; iss_long = 1; iss_rd = r;
  endtask

  task automatic retireTo(input logic [4:0] r, input logic [31:0] d);
    wr_en = 1; wr_long = 1; wr_addr = r; wr_data = d;
  endtask

  initial begin
    logic [4:0]  t_addr [4] = '{5'd1, 5'd12, 5'd20, 5'd31};
    logic [31:0] t_data [4] = '{32'h0000_0001, 32'hA5A5_5A5A, 32'h8000_0000, 32'hFFFF_FFFF};
    setIdle();
    reset = 0;
    repeat (2) tick();
    #1;
    checkOutput("reset_rd_data", rd_data, 64'h0);
    checkOutput("reset_busy", {63'h0, busy}, 64'h0);
    checkOutput("reset_sb_err", {63'h0, sb_err}, 64'h0);
    reset = 1;

    // Write-first bypass then stored value.
    tick();
    applyStimulus(5'd5, 5'd0, 2'b00);
    wr_en = 1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    #1 checkOutput("bypass_same_cycle", {32'h0, rd_data[31:0]}, 64'hDEADBEEF);
    tick();
    setIdle(); applyStimulus(5'd5, 5'd0, 2'b00);
    #1 checkOutput("stored_next_cycle", {32'h0, rd_data[31:0]}, 64'hDEADBEEF);

    // Pending dependency resolved by a same-cycle retire.
    tick();
    setIdle(); issueLong(5'd7);
    tick();
    setIdle(); applyStimulus(5'd7, 5'd0, 2'b01); iss_valid = 1; iss_rd = 5'd1;
    #1;
    checkOutput("r7_pend", {62'h0, rd_pend}, 64'h1);
    checkOutput("r7_stall", {63'h0, stall}, 64'h1);
    checkOutput("r7_busy", {63'h0, busy}, 64'h1);
    retireTo(5'd7, 32'h1234);
    #1;
    checkOutput("r7_retire_pend", {62'h0, rd_pend}, 64'h0);
    checkOutput("r7_retire_stall", {63'h0, stall}, 64'h0);
    checkOutput("r7_retire_data", {32'h0, rd_data[31:0]}, 64'h1234);
    tick();
    setIdle();
    #1 checkOutput("r7_busy_after", {63'h0, busy}, 64'h0);

    // Saturated counter on r9.
    for (int i = 0; i < 3; i++) begin
      tick(); setIdle(); issueLong(5'd9);
    end
    tick();
    setIdle(); issueLong(5'd9);
    #1 checkOutput("r9_full_stall", {63'h0, stall}, 64'h1);
    retireTo(5'd9, 32'h99);
    #1 checkOutput("r9_full_retire_stall", {63'h0, stall}, 64'h0);
    tick();
    setIdle(); issueLong(5'd9);
    #1 checkOutput("r9_still_full", {63'h0, stall}, 64'h1);
    for (int i = 0; i < 3; i++) begin
      tick(); setIdle(); retireTo(5'd9, 32'h90 + 32'(i));
    end
    tick();
    setIdle();
    #1 checkOutput("r9_drained_busy", {63'h0, busy}, 64'h0);

    // Retire with nothing outstanding.
    checkOutput("err_before", {63'h0, sb_err}, 64'h0);
    retireTo(5'd3, 32'h33);
    #1 checkOutput("err_same_cycle", {63'h0, sb_err}, 64'h0);
    tick();
    setIdle(); applyStimulus(5'd3, 5'd0, 2'b01);
    #1;
    checkOutput("err_set", {63'h0, sb_err}, 64'h1);
    checkOutput("r3_not_pend", {62'h0, rd_pend}, 64'h0);
    repeat (3) tick();
    #1 checkOutput("err_sticky", {63'h0, sb_err}, 64'h1);

    // Flush overrides a coincident issue.
    setIdle(); issueLong(5'd4);
    tick();
    setIdle(); issueLong(5'd6);
    tick();
    setIdle();
    #1 checkOutput("pend_busy", {63'h0, busy}, 64'h1);
    flush = 1; issueLong(5'd8);
    tick();
    setIdle(); applyStimulus(5'd4, 5'd8, 2'b11); iss_valid = 1;
    #1;
    checkOutput("flush_busy", {63'h0, busy}, 64'h0);
    checkOutput("flush_r8_pend", {62'h0, rd_pend}, 64'h0);

    // Register 0 ignores writes and issues.
    tick();
    setIdle(); applyStimulus(5'd0, 5'd0, 2'b11);
    wr_en = 1; wr_addr = 5'd0; wr_data = 32'h55;
    issueLong(5'd0);
    #1 checkOutput("zero_bypass", rd_data, 64'h0);
    tick();
    setIdle(); applyStimulus(5'd0, 5'd0, 2'b11);
    #1;
    checkOutput("zero_stored", rd_data, 64'h0);
    checkOutput("zero_busy", {63'h0, busy}, 64'h0);

    // Plain writes followed by reads on port 1.
    for (int i = 0; i < 4; i++) begin
      tick(); setIdle(); wr_en = 1; wr_addr = t_addr[i]; wr_data = t_data[i];
    end
    for (int i = 0; i < 4; i++) begin
      tick(); setIdle(); applyStimulus(5'd0, t_addr[i], 2'b10);
      #1 checkOutput("table_read", {32'h0, rd_data[63:32]}, {32'h0, t_data[i]});
    end

    // Asynchronous reset between edges.
    tick();
    setIdle(); wr_en = 1; wr_addr = 5'd2; wr_data = 32'hCAFE;
    tick();
    setIdle(); issueLong(5'd2);
    tick();
    setIdle(); applyStimulus(5'd2, 5'd0, 2'b00);
    #1;
    checkOutput("r2_before_reset", {32'h0, rd_data[31:0]}, 64'hCAFE);
    checkOutput("r2_pend_before", {62'h0, rd_pend}, 64'h1);
    reset = 0;
    #1;
    checkOutput("async_rd_data", {32'h0, rd_data[31:0]}, 64'h0);
    checkOutput("async_rd_pend", {62'h0, rd_pend}, 64'h0);
    checkOutput("async_busy", {63'h0, busy}, 64'h0);
    checkOutput("async_sb_err", {63'h0, sb_err}, 64'h0);
    tick();
    reset = 1;
    tick();
    #1;
    checkOutput("r2_after_release", {32'h0, rd_data[31:0]}, 64'h0);
    checkOutput("r2_pend_after", {62'h0, rd_pend}, 64'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
